// File: rtl/cpu_mem_stage_pkg.sv
// cpu_pkg: shared types and defaults for the CPU memory stage.
//   DefaultDataW / DefaultRegW : default data/address and register-index widths
//   mem_state_e                : memory-stage FSM states
//   byte_enable()              : byte-lane strobe for a given address offset and access size
package cpu_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultRegW  = 5;

  typedef enum logic [0:0] {
    IDLE,
    ACCESS
  } mem_state_e;

  function automatic logic [3:0] byte_enable(input logic [1:0] lane, input logic byte_acc);
    if (!byte_acc) begin
      return 4'b1111;
    end
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/cpu_mem_stage_if.sv
// cpu_mem_stage_if: EX/MEM inputs, data-memory bus, MEM/WB register and forwarding outputs.
//   in_*      : EX/MEM register contents (held by upstream while mem_stall is high)
//   mem_stall : back-pressure to upstream
//   dmem_*    : request/acknowledge data-memory bus
//   wb_*      : MEM/WB register feeding writeback
//   fw_*      : forwarding-unit view of the instruction currently in MEM
// Modports: master = pipeline/memory environment, slave = the memory stage.
interface cpu_mem_stage_if
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned REG_W  = DefaultRegW
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_alu_data;
  logic [DATA_W-1:0] in_store_data;
  logic [REG_W-1:0]  in_reg_dest;
  logic              in_mem_read;
  logic              in_mem_write;
  logic              in_byte;
  logic              in_reg_write;
  logic              in_mem_to_reg;
  logic              mem_stall;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [3:0]        dmem_be;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  logic              wb_valid;
  logic [DATA_W-1:0] wb_alu_data;
  logic [DATA_W-1:0] wb_mem_data;
  logic [REG_W-1:0]  wb_reg_dest;
  logic              wb_reg_write;
  logic              wb_mem_to_reg;

  logic [REG_W-1:0]  fw_rd_mem;
  logic              fw_reg_write_mem;
  logic [DATA_W-1:0] fw_mem_value;

  modport master (
    output in_valid, in_alu_data, in_store_data, in_reg_dest, in_mem_read, in_mem_write,
           in_byte, in_reg_write, in_mem_to_reg, dmem_ack, dmem_rdata,
    input  mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid,
           wb_alu_data, wb_mem_data, wb_reg_dest, wb_reg_write, wb_mem_to_reg, fw_rd_mem,
           fw_reg_write_mem, fw_mem_value
  );

  modport slave (
    input  in_valid, in_alu_data, in_store_data, in_reg_dest, in_mem_read, in_mem_write,
           in_byte, in_reg_write, in_mem_to_reg, dmem_ack, dmem_rdata,
    output mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid,
           wb_alu_data, wb_mem_data, wb_reg_dest, wb_reg_write, wb_mem_to_reg, fw_rd_mem,
           fw_reg_write_mem, fw_mem_value
  );

endinterface

// File: rtl/cpu_mem_stage_align.sv
// cpu_mem_align: combinational byte-lane logic for the memory stage.
//   i_lane       : address bits [1:0]
//   i_byte       : byte-size access
//   i_store_data : store operand
//   i_rdata      : word read from memory
//   o_be         : byte enables
//   o_wdata      : store data (byte replicated to every lane for byte stores)
//   o_load_data  : load result (selected byte zero-extended, or the whole word)
module cpu_mem_align
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic [1:0]        i_lane,
  input  logic              i_byte,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [3:0]        o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_load_data
);

  logic [7:0] w_load_byte;

  assign w_load_byte = i_rdata[{i_lane, 3'b000} +: 8];
  assign o_be        = byte_enable(i_lane, i_byte);
  assign o_wdata     = i_byte ? {(DATA_W / 8){i_store_data[7:0]}} : i_store_data;
  assign o_load_data = i_byte ? {{(DATA_W - 8){1'b0}}, w_load_byte} : i_rdata;

endmodule

// File: rtl/cpu_mem_stage.sv
// cpu_mem_stage: MEM pipeline stage with a request/ack data-memory port and MEM/WB register.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : cpu_mem_stage_if.slave (EX/MEM inputs, dmem bus, MEM/WB and forwarding outputs)
// Memory operations stall for one IDLE cycle plus the ACCESS wait; other instructions
// pass to MEM/WB in a single cycle.
module cpu_mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned REG_W  = DefaultRegW
) (
  input logic           clock,
  input logic           reset,
  cpu_mem_stage_if.slave bus
);

  mem_state_e r_state;
  mem_state_e w_state_next;

  logic              w_is_mem;
  logic              w_is_load;
  logic              w_req;
  logic              w_stall;
  logic              w_wb_load;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_load_data;

  logic              r_wb_valid;
  logic [DATA_W-1:0] r_wb_alu_data;
  logic [DATA_W-1:0] r_wb_mem_data;
  logic [REG_W-1:0]  r_wb_reg_dest;
  logic              r_wb_reg_write;
  logic              r_wb_mem_to_reg;

  assign w_is_mem  = bus.in_valid & (bus.in_mem_read | bus.in_mem_write);
  // A write wins over a simultaneous read.
  assign w_is_load = bus.in_mem_read & ~bus.in_mem_write;

  cpu_mem_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .i_lane       (bus.in_alu_data[1:0]),
    .i_byte       (bus.in_byte),
    .i_store_data (bus.in_store_data),
    .i_rdata      (bus.dmem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Ack is only meaningful in ACCESS; an ack in IDLE has no effect.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_is_mem) w_state_next = ACCESS;
      ACCESS:  if (bus.dmem_ack) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_req     = 1'b0;
    w_stall   = 1'b0;
    w_wb_load = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall   = w_is_mem;
        w_wb_load = bus.in_valid & ~w_is_mem;
      end
      ACCESS: begin
        w_req     = 1'b1;
        w_stall   = ~bus.dmem_ack;
        w_wb_load = bus.dmem_ack;
      end
      default: ;
    endcase
  end

  // Bubbles clear the write controls too so writeback cannot act on stale fields.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wb_valid      <= 1'b0;
      r_wb_alu_data   <= '0;
      r_wb_mem_data   <= '0;
      r_wb_reg_dest   <= '0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
    end else begin
      r_wb_valid <= w_wb_load;
      if (w_wb_load) begin
        r_wb_alu_data   <= bus.in_alu_data;
        r_wb_mem_data   <= (w_is_mem && w_is_load) ? w_load_data : '0;
        r_wb_reg_dest   <= bus.in_reg_dest;
        r_wb_reg_write  <= bus.in_reg_write;
        r_wb_mem_to_reg <= bus.in_mem_to_reg;
      end else begin
        r_wb_reg_write  <= 1'b0;
        r_wb_mem_to_reg <= 1'b0;
      end
    end
  end

  assign bus.mem_stall  = w_stall;
  assign bus.dmem_req   = w_req;
  assign bus.dmem_we    = w_req & bus.in_mem_write;
  assign bus.dmem_addr  = {bus.in_alu_data[DATA_W-1:2], 2'b00};
  assign bus.dmem_wdata = w_wdata;
  assign bus.dmem_be    = w_be;

  assign bus.wb_valid      = r_wb_valid;
  assign bus.wb_alu_data   = r_wb_alu_data;
  assign bus.wb_mem_data   = r_wb_mem_data;
  assign bus.wb_reg_dest   = r_wb_reg_dest;
  assign bus.wb_reg_write  = r_wb_reg_write;
  assign bus.wb_mem_to_reg = r_wb_mem_to_reg;

  assign bus.fw_rd_mem        = bus.in_reg_dest;
  assign bus.fw_reg_write_mem = bus.in_valid & bus.in_reg_write;
  assign bus.fw_mem_value     = bus.in_alu_data;

endmodule

// File: tb/tb_cpu_mem_stage.sv
// tb_cpu_mem_stage: table-driven bench for cpu_mem_stage with a MEM/WB scoreboard.
module tb_cpu_mem_stage;

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        mrd;
    logic        mwr;
    logic        byt;
    logic        rw;
    logic        m2r;
    int          ack_wait;
    logic [31:0] rdata;
    logic [31:0] exp_mem;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
  } wb_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   cyc;
  int   last_pop;
  int   prev_pop;
  wb_t  sb[$];
  vec_t vecs[10];

  cpu_mem_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

  cpu_mem_stage #(
    .DATA_W (32),
    .REG_W  (5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic [31:0] alu, input logic [31:0] store,
                              input logic [4:0] rd, input logic mrd, input logic mwr,
                              input logic byt, input logic rw, input logic m2r, input int aw,
                              input logic [31:0] rdata, input logic [31:0] exp_mem,
                              input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                              input logic [3:0] exp_be);
    vec_t v;
    v.valid = valid; v.alu = alu; v.store = store; v.rd = rd; v.mrd = mrd; v.mwr = mwr;
    v.byt = byt; v.rw = rw; v.m2r = m2r; v.ack_wait = aw; v.rdata = rdata;
    v.exp_mem = exp_mem; v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_be = exp_be;
    return v;
  endfunction

  // Scoreboard consumer: every valid MEM/WB output must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && bus.wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wb_unexpected: got wb_valid=1 with alu 0x%08h, expected no output",
                 bus.wb_alu_data);
      end else begin
        wb_t e;
        e = sb.pop_front();
        chk("wb_alu_data", bus.wb_alu_data, e.alu);
        chk("wb_mem_data", bus.wb_mem_data, e.mem);
        chk("wb_reg_dest", 32'(bus.wb_reg_dest), 32'(e.rd));
        chk("wb_reg_write", 32'(bus.wb_reg_write), 32'(e.rw));
        chk("wb_mem_to_reg", 32'(bus.wb_mem_to_reg), 32'(e.m2r));
        prev_pop = last_pop;
        last_pop = cyc;
      end
    end
  end

  task automatic chk_bus(input vec_t v);
    chk("dmem_req", 32'(bus.dmem_req), 32'd1);
    chk("dmem_addr", bus.dmem_addr, v.exp_addr);
    chk("dmem_be", 32'(bus.dmem_be), 32'(v.exp_be));
    chk("dmem_wdata", bus.dmem_wdata, v.exp_wdata);
    chk("dmem_we", 32'(bus.dmem_we), 32'(v.mwr));
  endtask

  // Entered and left at posedge+1.
  task automatic run_vec(input vec_t v);
    logic is_mem;
    int   stalls;
    wb_t  e;
    is_mem = v.valid & (v.mrd | v.mwr);
    bus.in_valid      = v.valid;
    bus.in_alu_data   = v.alu;
    bus.in_store_data = v.store;
    bus.in_reg_dest   = v.rd;
    bus.in_mem_read   = v.mrd;
    bus.in_mem_write  = v.mwr;
    bus.in_byte       = v.byt;
    bus.in_reg_write  = v.rw;
    bus.in_mem_to_reg = v.m2r;
    bus.dmem_ack      = 1'b0;
    bus.dmem_rdata    = v.rdata;
    if (v.valid) begin
      e.alu = v.alu; e.mem = v.exp_mem; e.rd = v.rd; e.rw = v.rw; e.m2r = v.m2r;
      sb.push_back(e);
    end
    #1;
    chk("fw_rd_mem", 32'(bus.fw_rd_mem), 32'(v.rd));
    chk("fw_reg_write_mem", 32'(bus.fw_reg_write_mem), 32'(v.valid & v.rw));
    chk("fw_mem_value", bus.fw_mem_value, v.alu);
    chk("stall_idle", 32'(bus.mem_stall), 32'(is_mem));
    if (!is_mem) begin
      chk("no_dmem_req", 32'(bus.dmem_req), 32'd0);
      @(posedge clock); #1;
      return;
    end
    stalls = 1;
    @(posedge clock); #1;
    for (int i = 0; i < v.ack_wait; i++) begin
      chk_bus(v);
      chk("stall_access", 32'(bus.mem_stall), 32'd1);
      chk("wb_bubble", 32'(bus.wb_valid), 32'd0);
      stalls++;
      @(posedge clock); #1;
    end
    bus.dmem_ack = 1'b1;
    #1;
    chk_bus(v);
    chk("stall_ack", 32'(bus.mem_stall), 32'd0);
    chk("wb_bubble_ack", 32'(bus.wb_valid), 32'd0);
    chk("stall_cycles", 32'(stalls), 32'(1 + v.ack_wait));
    @(posedge clock); #1;
    bus.dmem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    n_checks = 0; n_errors = 0; cyc = 0; last_pop = 0; prev_pop = 0;
    //          vld alu           store         rd   rd wr by rw m2r aw rdata
    //          exp_mem       exp_addr      exp_wdata     exp_be
    vecs[0] = mk(1, 32'h0000_1234, 32'h0,        3,  0, 0, 0, 1, 0, 0, 32'h0,
                 32'h0,        32'h0000_1234 & ~32'h3, 32'h0, 4'hF);
    vecs[1] = mk(1, 32'h0000_0100, 32'h1111_2222, 5, 1, 0, 0, 1, 1, 2, 32'hDEAD_BEEF,
                 32'hDEAD_BEEF, 32'h0000_0100, 32'h1111_2222, 4'b1111);
    vecs[2] = mk(1, 32'h0000_0103, 32'h0,        6,  1, 0, 1, 1, 1, 0, 32'hAABB_CCDD,
                 32'h0000_00AA, 32'h0000_0100, 32'h0,        4'b1000);
    vecs[3] = mk(1, 32'h0000_0201, 32'h1234_565A, 0, 0, 1, 1, 0, 1, 1, 32'hFFFF_FFFF,
                 32'h0,        32'h0000_0200, 32'h5A5A_5A5A, 4'b0010);
    vecs[4] = mk(1, 32'h0000_03FE, 32'hCAFE_F00D, 7, 0, 1, 0, 0, 0, 0, 32'h0,
                 32'h0,        32'h0000_03FC, 32'hCAFE_F00D, 4'b1111);
    vecs[5] = mk(1, 32'h0000_0012, 32'h0000_0077, 8, 1, 1, 1, 1, 1, 1, 32'h1234_5678,
                 32'h0,        32'h0000_0010, 32'h7777_7777, 4'b0100);
    vecs[6] = mk(1, 32'h0000_0042, 32'h0,        9,  1, 0, 1, 1, 1, 0, 32'h1122_3344,
                 32'h0000_0022, 32'h0000_0040, 32'h0,        4'b0100);
    vecs[7] = mk(1, 32'h0000_1000, 32'h0,        10, 1, 0, 1, 1, 1, 3, 32'h1122_3344,
                 32'h0000_0044, 32'h0000_1000, 32'h0,        4'b0001);
    vecs[8] = mk(1, 32'hFFFF_FFFF, 32'h0,        31, 0, 0, 0, 0, 0, 0, 32'h0,
                 32'h0,        32'hFFFF_FFFC, 32'h0,        4'hF);
    vecs[9] = mk(0, 32'h0000_0500, 32'h0,        4,  1, 0, 0, 1, 1, 0, 32'h0,
                 32'h0,        32'h0000_0500, 32'h0,        4'hF);

    bus.in_valid = 0; bus.in_alu_data = 0; bus.in_store_data = 0; bus.in_reg_dest = 0;
    bus.in_mem_read = 0; bus.in_mem_write = 0; bus.in_byte = 0; bus.in_reg_write = 0;
    bus.in_mem_to_reg = 0; bus.dmem_ack = 0; bus.dmem_rdata = 0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_reg_write", 32'(bus.wb_reg_write), 32'd0);
    chk("rst_wb_mem_to_reg", 32'(bus.wb_mem_to_reg), 32'd0);
    chk("rst_wb_alu_data", bus.wb_alu_data, 32'd0);
    chk("rst_wb_mem_data", bus.wb_mem_data, 32'd0);
    chk("rst_wb_reg_dest", 32'(bus.wb_reg_dest), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Ack while idle must not start or complete anything.
    bus.in_valid = 1'b0;
    bus.dmem_ack = 1'b1;
    #1;
    chk("idle_ack_req", 32'(bus.dmem_req), 32'd0);
    chk("idle_ack_stall", 32'(bus.mem_stall), 32'd0);
    @(posedge clock); #1;
    bus.dmem_ack = 1'b0;
    chk("idle_ack_wb", 32'(bus.wb_valid), 32'd0);

    // Back-to-back: load with a single-cycle ack, then an ALU op.
    run_vec(mk(1, 32'h0000_0600, 32'h0, 11, 1, 0, 0, 1, 1, 0, 32'h0BAD_F00D,
               32'h0BAD_F00D, 32'h0000_0600, 32'h0, 4'hF));
    run_vec(mk(1, 32'h0000_0777, 32'h0, 12, 0, 0, 0, 1, 0, 0, 32'h0,
               32'h0, 32'h0000_0774, 32'h0, 4'hF));
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("b2b_gap", 32'(last_pop - prev_pop), 32'd1);

    // Reset while in ACCESS, followed by a late ack.
    v = mk(1, 32'h0000_0800, 32'h0, 13, 1, 0, 0, 1, 1, 0, 32'h1, 32'h1, 32'h0000_0800,
           32'h0, 4'hF);
    bus.in_valid = 1'b1; bus.in_alu_data = v.alu; bus.in_reg_dest = v.rd;
    bus.in_mem_read = 1'b1; bus.in_mem_write = 1'b0; bus.in_byte = 1'b0;
    bus.in_reg_write = 1'b1; bus.in_mem_to_reg = 1'b1;
    @(posedge clock); #1;
    chk("rst_access_req_before", 32'(bus.dmem_req), 32'd1);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_access_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_access_wb", 32'(bus.wb_valid), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    bus.dmem_ack = 1'b1;
    #1;
    chk("late_ack_req", 32'(bus.dmem_req), 32'd0);
    chk("late_ack_stall", 32'(bus.mem_stall), 32'd0);
    @(posedge clock); #1;
    bus.dmem_ack = 1'b0;
    chk("late_ack_wb", 32'(bus.wb_valid), 32'd0);
    chk("late_ack_idle", 32'(bus.dmem_req), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_mem_stage.md
CPU_MEM_STAGE -- requirements
Module: cpu_mem_stage

Interface
REQ-001 Parameter DATA_W, default 32, data and address width.
REQ-002 Parameter REG_W, default 5, register index width.
REQ-003 clock  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  the EX/MEM register holds a real instruction.
REQ-006 in_alu_data  in  DATA_W  ALU result, also the memory address.
REQ-007 in_store_data  in  DATA_W  store operand.
REQ-008 in_reg_dest  in  REG_W  destination register.
REQ-009 in_mem_read / in_mem_write / in_byte  in  1 each  load, store, byte-size access.
REQ-010 in_reg_write / in_mem_to_reg  in  1 each  writeback controls, passed through.
REQ-011 mem_stall  out  1  upstream holds all in_* while this is high.
REQ-012 dmem_req / dmem_we  out  1 each  memory request and write strobe.
REQ-013 dmem_addr  out  DATA_W  word-aligned address.
REQ-014 dmem_wdata  out  DATA_W  store data.
REQ-015 dmem_be  out  4  byte enables.
REQ-016 dmem_ack  in  1  request complete.
REQ-017 dmem_rdata  in  DATA_W  read word, valid with dmem_ack.
REQ-018 wb_valid, wb_alu_data, wb_mem_data, wb_reg_dest, wb_reg_write, wb_mem_to_reg  out  MEM/WB register feeding writeback.
REQ-019 fw_rd_mem  out  REG_W  forwarding-unit outputs, together with REQ-020 and REQ-021.
REQ-020 fw_reg_write_mem  out  1  forwarding-unit output.
REQ-021 fw_mem_value  out  DATA_W  forwarding-unit output.

Function
REQ-022 The FSM SHALL have two states, IDLE and ACCESS.
REQ-023 In IDLE, an in_valid memory operation SHALL assert mem_stall combinationally and move to ACCESS at the next edge.
REQ-024 In ACCESS, dmem_req SHALL be high and addr, wdata, we and be SHALL be stable until dmem_ack.
REQ-025 In ACCESS, mem_stall = !dmem_ack.
REQ-026 On the edge where dmem_ack is sampled, the FSM SHALL return to IDLE and the MEM/WB register SHALL load with wb_valid=1.
REQ-027 Non-memory instructions (in_valid, no read or write) SHALL load the MEM/WB register at the next edge with no stall, giving 1-cycle latency.
REQ-028 wb_valid SHALL be 0 after any edge where mem_stall was high or in_valid was low (bubble insertion).
REQ-029 dmem_addr = {in_alu_data[DATA_W-1:2], 2'b00}.
REQ-030 Word access: dmem_be=4'b1111 and wdata = in_store_data.
REQ-031 Byte access: dmem_be is one-hot at in_alu_data[1:0] and wdata replicates in_store_data[7:0] into all 4 lanes.
REQ-032 Byte load: wb_mem_data = the selected rdata byte, zero-extended.
REQ-033 Word load: wb_mem_data = dmem_rdata.
REQ-034 For a store, wb_mem_data SHALL be 0.
REQ-035 A simultaneous load and write SHALL be treated as a store.
REQ-036 dmem_ack while IDLE SHALL be ignored.
REQ-037 fw_rd_mem = in_reg_dest, fw_reg_write_mem = in_valid & in_reg_write, fw_mem_value = in_alu_data; all combinational.

Reset
REQ-038 Reset SHALL force IDLE and drive dmem_req, wb_valid, wb_reg_write and wb_mem_to_reg to 0.
REQ-039 Reset SHALL drive all wb data fields to 0.
REQ-040 Reset during ACCESS SHALL abandon the request, and a later ack SHALL be ignored per REQ-036.

Structure
REQ-041 cpu_pkg SHALL hold the mem_state_e enum (IDLE, ACCESS) and the DATA_W and REG_W defaults.
REQ-042 The byte-lane logic (be, store replication, load extract) SHALL live in a combinational sub-module cpu_mem_align.

Verification
REQ-043 ALU op: alu=0x1234, rd=3, reg_write=1 -> next edge wb_valid=1, wb_alu_data=0x1234, no stall, no dmem_req.
REQ-044 Word load at 0x100 with ack 3 cycles after req, rdata=0xDEADBEEF -> mem_stall high 3 cycles, then wb_mem_data=0xDEADBEEF and addr=0x100; intermediate wb_valid=0.
REQ-045 Byte load at 0x103, rdata=0xAABBCCDD -> wb_mem_data=0x000000AA, be=4'b1000.
REQ-046 Byte store 0x5A at 0x201 -> addr=0x200, be=4'b0010, wdata=0x5A5A5A5A, we=1, wb_mem_to_reg passed through.
REQ-047 Reset asserted in ACCESS, ack given one cycle later -> dmem_req=0, wb_valid=0, FSM stays IDLE.
REQ-048 Back-to-back: load (ack after 1 cycle) followed by an ALU op -> ALU result appears on wb_* one cycle after the load result.
